// File: rtl/if_id_skid.sv
// ============================================================================
// Module      : if_id_skid
// Description : Two-entry in-order skid buffer between the fetch stage and the
//               decode stage of a pipelined core.  The main register drives
//               out_pc/out_instr; the skid register absorbs one extra entry so
//               that in_ready can be a registered signal with no combinational
//               path from out_ready.  A flush discards every held entry.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PC_W      : program-counter width (default 8)
//   INSTR_W   : instruction word width (default 32)
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous reset, active low (0 = in reset)
//   flush      in   synchronous discard of all entries (taken branch/jump)
//   in_valid   in   fetch offers in_pc/in_instr
//   in_ready   out  buffer accepts the offer this cycle (registered)
//   in_pc      in   PC of the offered instruction
//   in_instr   in   offered instruction word
//   out_valid  out  out_pc/out_instr hold a valid entry for decode
//   out_ready  in   decode consumes the head entry this cycle
//   out_pc     out  PC of the head entry
//   out_instr  out  instruction of the head entry
//   bubble_cnt out  saturating decode-starvation counter
//                   (present only when IF_ID_BUBBLE_COUNT_EN is defined)
// Configuration macro
//   IF_ID_BUBBLE_COUNT_EN : compiles in the bubble_cnt port and its counter
// ============================================================================

`default_nettype none

module if_id_skid #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_BUBBLE_COUNT_EN
    ,
    output logic [7:0]         bubble_cnt
`endif
);

    // ------------------------------------------------------------------------
    // State encoding: number of entries currently held.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic                 in_ready_q,   in_ready_d;
    logic                 out_valid_q,  out_valid_d;
    logic [PC_W-1:0]      main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [PC_W-1:0]      skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;

    logic                 w_accept;
    logic                 w_pop;

    // Handshakes are qualified by the registered flags only, so neither
    // in_ready nor out_valid ever depends combinationally on the far side.
    assign w_accept = in_valid  & in_ready_q;
    assign w_pop    = out_valid_q & out_ready;

    // ------------------------------------------------------------------------
    // Next-state and datapath selection.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Only the occupancy clears; the main register keeps its last
            // contents so out_pc/out_instr do not glitch on a flush, and any
            // offer made in the same cycle is simply not captured.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                        state_d      = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        // Head leaves and the new entry replaces it directly.
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (w_accept) begin
                        // Decode stalled: park the new entry behind the head.
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                        state_d      = ST_TWO;
                    end else if (w_pop) begin
                        state_d      = ST_EMPTY;
                    end
                end

                ST_TWO: begin
                    // in_ready is low here, so no accept can coincide.
                    if (w_pop) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        state_d      = ST_ONE;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Flags are derived from the next state and registered, giving
        // a full cycle of timing slack on both handshake outputs.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // ------------------------------------------------------------------------
    // Decode-starvation counter.
    // ------------------------------------------------------------------------
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [7:0] bubble_q;
    logic [7:0] bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        // Decode was ready but had nothing to take; stop at all-ones.
        if (out_ready && !out_valid_q && (bubble_q != 8'hFF)) begin
            bubble_d = bubble_q + 8'd1;
        end
    end

    assign bubble_cnt = bubble_q;
`endif

    // ------------------------------------------------------------------------
    // Registers.  in_ready resets low and rises on the first edge after the
    // reset is released because in_ready_d is 1 in the empty state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
`ifdef IF_ID_BUBBLE_COUNT_EN
            bubble_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`ifdef IF_ID_BUBBLE_COUNT_EN
            bubble_q     <= bubble_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid.sv
// ============================================================================
// Module      : tb_if_id_skid
// Description : Self-checking bench for if_id_skid.  A queue-based reference
//               model tracks the entries held by the buffer; a monitor on the
//               falling edge compares the DUT outputs against it.  Directed
//               sequences cover reset, the two-entry stall, flush and
//               asynchronous reset; a random phase mixes flush and back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_if_id_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pc = 8'h00;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [7:0]  bubble_cnt;
`endif

    if_id_skid #(
        .PC_W    (8),
        .INSTR_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
`ifdef IF_ID_BUBBLE_COUNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a FIFO of at most two accepted entries.  The head is
    // what decode sees; the last head stays visible when the FIFO empties.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    bit          m_rdy   = 1'b0;
    logic [7:0]  m_pc    = 8'h00;
    logic [31:0] m_instr = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_rdy   = 1'b0;
            m_pc    = 8'h00;
            m_instr = 32'h0;
        end else begin
            bit acc;
            acc = in_valid && m_rdy;
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back('{pc: in_pc, instr: in_instr});
            end
            if (q.size() > 0) begin
                m_pc    = q[0].pc;
                m_instr = q[0].instr;
            end
            m_rdy = (q.size() < 2);
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: compares the DUT against the model away from the active edge
    // and logs every PC that decode consumes.
    // ------------------------------------------------------------------------
    bit         log_en = 1'b0;
    logic [7:0] delivered[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("mon_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("mon_in_ready",  64'(in_ready),  64'(m_rdy));
            chk("mon_out_pc",    64'(out_pc),    64'(m_pc));
            chk("mon_out_instr", 64'(out_instr), 64'(m_instr));
            if (log_en && out_valid && out_ready && !flush) delivered.push_back(out_pc);
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        bit acc;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
`ifdef IF_ID_BUBBLE_COUNT_EN
        chk("rst_bubble",    64'(bubble_cnt), 64'd0);
`endif
        #2 reset = 1'b1;
        cyc();
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // ---------------- single transfer ----------------
        in_valid = 1'b1; in_pc = 8'h04; in_instr = 32'h00500093; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_pc",    64'(out_pc),    64'h04);
        chk("first_out_instr", 64'(out_instr), 64'h00500093);
        chk("first_in_ready",  64'(in_ready),  64'd1);
        cyc();

        // ---------------- two-entry stall ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 8'h10; in_instr = 32'h1010_1010;
        cyc();
        in_pc = 8'h14; in_instr = 32'h1414_1414;
        cyc();
        in_valid = 1'b0;
        chk("full_in_ready",  64'(in_ready),  64'd0);
        chk("full_out_pc",    64'(out_pc),    64'h10);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("drain1_out_pc",    64'(out_pc),    64'h14);
        chk("drain1_out_valid", 64'(out_valid), 64'd1);
        chk("drain1_in_ready",  64'(in_ready),  64'd1);
        cyc();
        chk("drain2_out_valid", 64'(out_valid), 64'd0);

        // ---------------- flush with simultaneous offer ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 8'h10; in_instr = 32'h1010_1010;
        cyc();
        in_pc = 8'h14; in_instr = 32'h1414_1414;
        cyc();
        flush = 1'b1; in_pc = 8'h18; in_instr = 32'h1818_1818;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        chk("flush_out_pc",    64'(out_pc),    64'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_no_18", 64'(out_valid), 64'd0);
        end

        // ---------------- ordered stream, random back-pressure ----------------
        delivered.delete();
        log_en = 1'b1;
        idx = 0;
        for (int c = 0; c < 2000 && delivered.size() < 16; c++) begin
            in_valid  = (idx < 16) && ($urandom_range(0, 3) != 0);
            in_pc     = 8'(idx * 4);
            in_instr  = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            cyc();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        log_en   = 1'b0;
        chk("stream_count", 64'(delivered.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < delivered.size()) chk("stream_order", 64'(delivered[i]), 64'(i * 4));
        end

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 8'h40; in_instr = 32'h4040_4040;
        cyc();
        in_pc = 8'h44; in_instr = 32'h4444_4444;
        cyc();
        in_valid = 1'b0;
        chk("pre_arst_out_pc", 64'(out_pc), 64'h40);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_pc",    64'(out_pc),    64'd0);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        cyc();
        chk("arst_release_in_ready", 64'(in_ready), 64'd1);

        // ---------------- random mix incl. flush ----------------
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = 8'($urandom);
            in_instr  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

`ifdef IF_ID_BUBBLE_COUNT_EN
        // ---------------- bubble counter saturation ----------------
        out_ready = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (100) cyc();
        chk("bubble_100", 64'(bubble_cnt), 64'd100);
        repeat (200) cyc();
        chk("bubble_sat", 64'(bubble_cnt), 64'd255);
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
